// File: rtl/rtmc_stepper.sv
// Single-axis stepper sequencer: accepts move commands and emits timed steps on a 4-coil phase table.
// First step lands eff_period cycles after accept; coil outputs lag the phase index by one register stage.
// Backpressure: cmd_ready is low while a move runs, when the axis is disabled, or while abort is high.
module rtmc_stepper #(
    parameter int PER_W  = 16,
    parameter int STEP_W = 16,
    parameter int POS_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    half_step,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [STEP_W-1:0]       cmd_steps,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] pos,
    output logic [3:0]              coil,
    output logic [3:0]              coil_oe
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic              done_nxt;
    logic [2:0]        idx, idx_nxt, inc;
    logic              dir_q;
    logic [STEP_W-1:0] remaining;
    logic [PER_W-1:0]  period_q, timer, eff_period;
    logic              accept, step_evt, stop;

    function automatic logic [3:0] phase_pat(input logic [2:0] i);
        case (i)
            3'd0:    phase_pat = 4'b1000;
            3'd1:    phase_pat = 4'b1100;
            3'd2:    phase_pat = 4'b0100;
            3'd3:    phase_pat = 4'b0110;
            3'd4:    phase_pat = 4'b0010;
            3'd5:    phase_pat = 4'b0011;
            3'd6:    phase_pat = 4'b0001;
            default: phase_pat = 4'b1001;
        endcase
    endfunction

    assign cmd_ready  = (state == IDLE) & en & ~abort;
    assign accept     = cmd_valid & cmd_ready;
    assign busy       = (state == RUN);
    assign step_evt   = (state == RUN) & (timer == PER_W'(1));
    assign stop       = abort | ~en;
    assign eff_period = (cmd_period == '0) ? PER_W'(1) : cmd_period;

    // Full-step from a single-coil (even) phase only moves one slot, landing on the
    // adjacent two-coil phase in the direction of travel.
    always_comb begin
        inc = 3'd2;
        if (half_step || !idx[0])
            inc = 3'd1;
        idx_nxt = dir_q ? idx + inc : idx - inc;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_steps != '0)
                        state_nxt = RUN;
                    else
                        done_nxt = 1'b1;
                end
            end
            RUN: begin
                if ((step_evt && remaining == STEP_W'(1)) || stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pos       <= '0;
            coil      <= '0;
            coil_oe   <= '0;
            dir_q     <= 1'b0;
            remaining <= '0;
            period_q  <= '0;
            timer     <= '0;
        end else begin
            coil    <= en ? phase_pat(idx) : 4'b0000;
            coil_oe <= {4{en}};
            if (accept) begin
                dir_q     <= cmd_dir;
                remaining <= cmd_steps;
                period_q  <= eff_period;
                timer     <= eff_period;
            end else if (step_evt) begin
                // A step coinciding with abort/disable is still applied.
                timer     <= period_q;
                idx       <= idx_nxt;
                pos       <= dir_q ? pos + POS_W'(1) : pos - POS_W'(1);
                remaining <= remaining - STEP_W'(1);
            end else if (state == RUN) begin
                timer <= timer - PER_W'(1);
            end
        end
    end

endmodule
